lsu_byte_sequencer: RTL

Load/store unit between the riscv core's memory stage and the byte-wide data memory (8-bit mem array, 128 entries).
- Accepts one lb/lh/lw/lbu/lhu/sb/sh/sw request per handshake.
- Splits each request into little-endian byte accesses, one per cycle.
- Returns load data sign- or zero-extended to XLEN, with a single-cycle response pulse.

---
 rtl/lsu_byte_sequencer_pkg.sv | 41 ++++
 rtl/lsu_byte_sequencer_load_extend.sv | 25 ++
 rtl/lsu_byte_sequencer.sv | 137 +++++++++++++
 3 files changed

// File: rtl/lsu_byte_sequencer_pkg.sv
// Shared definitions for the byte-serial load/store unit: funct3 codes,
// FSM encoding and the access-size decoder.
package lsu_byte_sequencer_pkg;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   typedef enum logic [2:0] {
      IDLE,
      ERR,
      WRITE,
      READ,
      RWAIT,
      RESP
   } state_t;

   typedef struct packed {
      logic [2:0] n;      // byte count: 1, 2 or 4
      logic       legal;
   } sz_t;

   // Byte count and legality of a funct3; unsigned variants exist only for loads.
   function automatic sz_t size_decode(input logic [2:0] f3, input logic wr);
      sz_t s;
      s.n     = 3'd0;
      s.legal = 1'b0;
      case (f3)
         F3_B:  begin s.n = 3'd1; s.legal = 1'b1; end
         F3_H:  begin s.n = 3'd2; s.legal = 1'b1; end
         F3_W:  begin s.n = 3'd4; s.legal = 1'b1; end
         F3_BU: begin s.n = 3'd1; s.legal = !wr;  end
         F3_HU: begin s.n = 3'd2; s.legal = !wr;  end
         default: ;
      endcase
      return s;
   endfunction

endpackage

// File: rtl/lsu_byte_sequencer_load_extend.sv
// Sign/zero extension of the assembled little-endian load bytes by funct3.
module load_extend
   import lsu_byte_sequencer_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic [31:0]     raw,
   input  logic [2:0]      funct3,
   output logic [XLEN-1:0] data
);

   // Size casts of signed operands sign-extend; unsigned ones zero-extend.
   always_comb begin
      data = '0;
      case (funct3)
         F3_B:  data = XLEN'($signed(raw[7:0]));
         F3_H:  data = XLEN'($signed(raw[15:0]));
         F3_W:  data = XLEN'(raw);
         F3_BU: data = XLEN'(raw[7:0]);
         F3_HU: data = XLEN'(raw[15:0]);
         default: data = '0;
      endcase
   end

endmodule

// File: rtl/lsu_byte_sequencer.sv
// Load/store sequencer: splits a core request into one byte access per cycle
// against a byte-wide synchronous-read data memory.
module lsu_byte_sequencer
   import lsu_byte_sequencer_pkg::*;
#(
   parameter int XLEN   = 32,
   parameter int ADDR_W = 7
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_write,
   input  logic [2:0]        req_funct3,
   input  logic [XLEN-1:0]   req_addr,
   input  logic [XLEN-1:0]   req_wdata,
   output logic              resp_valid,
   output logic              resp_err,
   output logic [XLEN-1:0]   resp_rdata,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_we,
   output logic [7:0]        mem_wdata,
   input  logic [7:0]        mem_rdata
);

   state_t            state, nstate;
   logic [ADDR_W-1:0] addr_r;
   logic [XLEN-1:0]   wdata_r;
   logic [2:0]        f3_r;
   logic              wr_r;
   logic [1:0]        cnt, last_r;
   logic [31:0]       cap;
   logic              rd_pend;
   logic [1:0]        rd_idx;
   logic [XLEN-1:0]   ext;
   sz_t               sz;
   logic              mis;
   logic              unused_addr;

   // Addresses wrap modulo the memory size; the upper bits are dropped.
   assign unused_addr = ^req_addr[XLEN-1:ADDR_W];

   assign sz  = size_decode(req_funct3, req_write);
   assign mis = ((sz.n == 3'd2) && req_addr[0]) ||
                ((sz.n == 3'd4) && (req_addr[1:0] != 2'b00));

   load_extend #(.XLEN(XLEN)) u_ext (
      .raw    (cap),
      .funct3 (f3_r),
      .data   (ext)
   );

   // State register plus request latch, byte counter and load capture.
   // A byte read issued in one cycle arrives the next, so rd_pend/rd_idx
   // remember where it belongs.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state   <= IDLE;
         addr_r  <= '0;
         wdata_r <= '0;
         f3_r    <= '0;
         wr_r    <= 1'b0;
         cnt     <= '0;
         last_r  <= '0;
         cap     <= '0;
         rd_pend <= 1'b0;
         rd_idx  <= '0;
      end else begin
         state   <= nstate;
         rd_pend <= 1'b0;
         case (state)
            IDLE: if (req_valid) begin
               addr_r  <= req_addr[ADDR_W-1:0];
               wdata_r <= req_wdata;
               f3_r    <= req_funct3;
               wr_r    <= req_write;
               last_r  <= sz.n[1:0] - 2'd1;
               cnt     <= '0;
               cap     <= '0;
            end
            WRITE: cnt <= cnt + 2'd1;
            READ: begin
               cnt     <= cnt + 2'd1;
               rd_pend <= 1'b1;
               rd_idx  <= cnt;
            end
            default: ;
         endcase
         if (rd_pend) cap[{rd_idx, 3'b000} +: 8] <= mem_rdata;
      end
   end

   // Next state and all outputs; memory outputs stay 0 unless issuing.
   always_comb begin
      nstate     = state;
      req_ready  = 1'b0;
      resp_valid = 1'b0;
      resp_err   = 1'b0;
      resp_rdata = '0;
      mem_addr   = '0;
      mem_we     = 1'b0;
      mem_wdata  = '0;
      case (state)
         IDLE: begin
            req_ready = 1'b1;
            if (req_valid) begin
               if (!sz.legal || mis) nstate = ERR;
               else if (req_write)   nstate = WRITE;
               else                  nstate = READ;
            end
         end
         ERR: begin
            resp_valid = 1'b1;
            resp_err   = 1'b1;
            nstate     = IDLE;
         end
         WRITE: begin
            mem_we    = 1'b1;
            mem_addr  = addr_r + ADDR_W'(cnt);
            mem_wdata = wdata_r[{cnt, 3'b000} +: 8];
            if (cnt == last_r) nstate = RESP;
         end
         READ: begin
            mem_addr = addr_r + ADDR_W'(cnt);
            if (cnt == last_r) nstate = RWAIT;
         end
         RWAIT: nstate = RESP;
         RESP: begin
            resp_valid = 1'b1;
            resp_rdata = wr_r ? '0 : ext;
            nstate     = IDLE;
         end
         default: nstate = IDLE;
      endcase
   end

endmodule
